// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display blocks: active-low segment
// patterns, the scan reader state type and the pattern-to-hex lookup.
package seg7_pkg;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef enum logic {
        COLLECT = 1'b0,
        PUBLISH = 1'b1
    } state_t;

    // Returns {known, nibble}; unknown patterns give {0, 0}
    function automatic logic [4:0] seg_to_hex(input logic [6:0] seg_n);
        case (seg_n)
            SEG_0:   return {1'b1, 4'h0};
            SEG_1:   return {1'b1, 4'h1};
            SEG_2:   return {1'b1, 4'h2};
            SEG_3:   return {1'b1, 4'h3};
            SEG_4:   return {1'b1, 4'h4};
            SEG_5:   return {1'b1, 4'h5};
            SEG_6:   return {1'b1, 4'h6};
            SEG_7:   return {1'b1, 4'h7};
            SEG_8:   return {1'b1, 4'h8};
            SEG_9:   return {1'b1, 4'h9};
            SEG_A:   return {1'b1, 4'hA};
            SEG_B:   return {1'b1, 4'hB};
            SEG_C:   return {1'b1, 4'hC};
            SEG_D:   return {1'b1, 4'hD};
            SEG_E:   return {1'b1, 4'hE};
            SEG_F:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

endpackage

// File: rtl/seg7_pattern_match.sv
// Combinational seven-segment pattern to hex nibble lookup.
module seg7_pattern_match
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       known,
    output logic [3:0] nibble
);

    // Table lookup of the active-low segment pattern
    always_comb begin
        {known, nibble} = seg_to_hex(seg_n);
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed active-low seven-segment bus: debounces each digit
// strobe, decodes the stable pattern and publishes the assembled word once
// every digit has been captured.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                sample_en,
    input  logic [6:0]          seg_n,
    input  logic [DIGITS-1:0]   dig_sel,
    output logic [4*DIGITS-1:0] value,
    output logic                valid,
    output logic                err,
    output logic [DIGITS-1:0]   digit_err
);

    localparam int SW    = 7 + DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SW-1:0]         cur;
    logic [SW-1:0]         prev;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  same;
    logic                  onehot;
    logic [IDX_W-1:0]      dig_idx;
    logic                  capture;
    logic                  known;
    logic [3:0]            nibble;

    logic [4*DIGITS-1:0]   shadow;
    logic [4*DIGITS-1:0]   shadow_nxt;
    logic [DIGITS-1:0]     shadow_err;
    logic [DIGITS-1:0]     shadow_err_nxt;
    logic [DIGITS-1:0]     captured;
    logic [DIGITS-1:0]     captured_nxt;

    state_t                state;
    state_t                state_nxt;
    logic                  publish;

    assign cur   = {seg_n, dig_sel};
    assign same  = (cur == prev);
    assign valid = (state == PUBLISH);

    seg7_pattern_match u_match (
        .seg_n  (seg_n),
        .known  (known),
        .nibble (nibble)
    );

    // Stability counter: restarts on any bus change, saturates at STABLE_CNT
    always_comb begin
        cnt_nxt = CNT_ONE;
        if (same) begin
            if (cnt >= CNT_MAX) cnt_nxt = CNT_MAX;
            else                cnt_nxt = cnt + CNT_ONE;
        end
    end

    // Strobe decode: exactly-one-hot check and index of the selected digit
    always_comb begin
        onehot  = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
        dig_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_sel[i]) dig_idx = IDX_W'(i);
        end
    end

    // A run captures once, on the edge the counter reaches STABLE_CNT
    assign capture = sample_en && same && (cnt == CNT_PRE) && onehot;

    // Frame bookkeeping: publish clears first, then a coincident capture lands
    always_comb begin
        shadow_nxt     = shadow;
        shadow_err_nxt = publish ? '0 : shadow_err;
        captured_nxt   = publish ? '0 : captured;
        if (capture) begin
            captured_nxt[dig_idx] = 1'b1;
            shadow_err_nxt[dig_idx] = ~known;
            if (known) shadow_nxt[int'(dig_idx)*4 +: 4] = nibble;
        end
    end

    // Next state: publish as soon as every digit is captured, then one cycle in PUBLISH
    always_comb begin
        state_nxt = state;
        publish   = 1'b0;
        case (state)
            COLLECT: begin
                if (&captured) begin
                    publish   = 1'b1;
                    state_nxt = PUBLISH;
                end
            end
            PUBLISH: state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Sample history, advanced only on sampling ticks
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev <= '0;
            cnt  <= '0;
        end else if (sample_en) begin
            prev <= cur;
            cnt  <= cnt_nxt;
        end
    end

    // Shadow word, error mask and captured mask
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow     <= '0;
            shadow_err <= '0;
            captured   <= '0;
        end else begin
            shadow     <= shadow_nxt;
            shadow_err <= shadow_err_nxt;
            captured   <= captured_nxt;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= COLLECT;
        else         state <= state_nxt;
    end

    // Published outputs, held between valid pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value     <= '0;
            err       <= 1'b0;
            digit_err <= '0;
        end else if (publish) begin
            value     <= shadow;
            err       <= |shadow_err;
            digit_err <= shadow_err;
        end
    end

endmodule
